// File: rtl/instr_enc_if.sv
// instr_enc_if: request and output-word handshake bundle for instr_encoder
// Ports: master drives requests and accepts words, slave is the encoder side.
// Fields: in_valid/in_ready/in_class/in_rs/in_rt/in_rd/in_funct/in_imm, out_valid/out_ready/out_instr/out_addr.
interface instr_enc_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [25:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  modport master (
    output in_valid, in_class, in_rs, in_rt, in_rd, in_funct, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );
  modport slave (
    input  in_valid, in_class, in_rs, in_rt, in_rd, in_funct, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS instruction requests into 32-bit words and queues them with word addresses
// Ports: clk, rst (sync active-high), clear (sync flush), bus (instr_enc_if.slave),
//        err (sticky illegal-class flag), level (FIFO occupancy).
// Macro INSTR_ENC_CHECK_EN enables the sticky err flag; without it err is tied to 0.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  instr_enc_if.slave               bus,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       cnt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic              full, push, pop;
  assign full          = cnt == (AW+1)'(DEPTH);
  assign bus.in_ready  = !full && !clear;
  assign bus.out_valid = cnt != '0;
  assign bus.out_instr = mem[rp];
  assign bus.out_addr  = addr;
  assign level         = cnt;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready && !clear;
  always_comb begin
    word = 32'h0;
    case (bus.in_class)
      3'd0: word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, bus.in_funct};
      3'd1: word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      3'd2: word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      3'd3: word = {6'h02, bus.in_imm};
      3'd4: word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      3'd5: word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      default: word = 32'h0;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= word;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      addr <= '0;
    end else begin
      wp   <= push ? wp + 1'b1 : wp;
      rp   <= pop ? rp + 1'b1 : rp;
      cnt  <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      addr <= pop ? addr + 1'b1 : addr;
    end
  end
`ifdef INSTR_ENC_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || clear) err <= 1'b0;
    else if (push && bus.in_class > 3'd5) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder
module tb_instr_encoder;
  localparam logic EXP_ERR =
`ifdef INSTR_ENC_CHECK_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk, rst, clear, clear2, err, err2;
  logic [2:0] level, level2;
  int checks = 0;
  int errors = 0;
  instr_enc_if #(.ADDR_W(10)) b ();
  instr_enc_if #(.ADDR_W(2))  b2 ();
  instr_encoder #(.DEPTH(4), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(b), .err(err), .level(level)
  );
  instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear2), .bus(b2), .err(err2), .level(level2)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [5:0] f, input logic [25:0] imm);
    b.in_valid = 1'b1;
    b.in_class = c;
    b.in_rs    = rs;
    b.in_rt    = rt;
    b.in_rd    = rd;
    b.in_funct = f;
    b.in_imm   = imm;
  endtask
  initial begin
    rst = 1'b1; clear = 1'b0; clear2 = 1'b0;
    b.in_valid = 0; b.in_class = 0; b.in_rs = 0; b.in_rt = 0; b.in_rd = 0;
    b.in_funct = 0; b.in_imm = 0; b.out_ready = 0;
    b2.in_valid = 0; b2.in_class = 0; b2.in_rs = 0; b2.in_rt = 0; b2.in_rd = 0;
    b2.in_funct = 0; b2.in_imm = 0; b2.out_ready = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", b.in_ready, 1);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", b.out_addr, 0);
    // R-type into empty FIFO
    req(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 26'd0);
    step();
    b.in_valid = 0;
    chk("r_valid", b.out_valid, 1);
    chk("r_instr", b.out_instr, 32'h0022_1820);
    chk("r_addr", b.out_addr, 0);
    chk("r_level", level, 1);
    b.out_ready = 1;
    step();
    b.out_ready = 0;
    chk("pop_empty", b.out_valid, 0);
    chk("pop_addr", b.out_addr, 1);
    clear = 1;
    #1;
    chk("clear_in_ready", b.in_ready, 0);
    step();
    clear = 0;
    chk("clear_addr", b.out_addr, 0);
    // LW then J with consumer ready
    req(3'd4, 5'd29, 5'd8, 5'd0, 6'd0, 26'h000_FFFC);
    step();
    chk("lw_instr", b.out_instr, 32'h8FA8_FFFC);
    chk("lw_addr", b.out_addr, 0);
    req(3'd3, 5'd0, 5'd0, 5'd0, 6'd0, 26'h000_0010);
    b.out_ready = 1;
    step();
    b.in_valid = 0;
    chk("j_instr", b.out_instr, 32'h0800_0010);
    chk("j_addr", b.out_addr, 1);
    chk("j_level", level, 1);
    step();
    b.out_ready = 0;
    chk("j_drained", level, 0);
    chk("j_addr_after", b.out_addr, 2);
    // fill to full with ADDI, then try a 5th push
    for (int i = 0; i < 4; i++) begin
      req(3'd1, 5'(i), 5'(i), 5'd0, 6'd0, 26'(i));
      step();
    end
    chk("full_in_ready", b.in_ready, 0);
    chk("full_level", level, 4);
    chk("full_head", b.out_instr, 32'h2000_0000);
    req(3'd2, 5'd9, 5'd9, 5'd0, 6'd0, 26'h1234);
    step();
    chk("fifth_level", level, 4);
    chk("fifth_head", b.out_instr, 32'h2000_0000);
    chk("fifth_addr", b.out_addr, 2);
    // full: pop and push offered together -> only the pop happens
    b.out_ready = 1;
    step();
    b.in_valid = 0;
    chk("full_pp_level", level, 3);
    chk("order1", b.out_instr, 32'h2021_0001);
    step();
    chk("order2", b.out_instr, 32'h2042_0002);
    step();
    chk("order3", b.out_instr, 32'h2063_0003);
    step();
    b.out_ready = 0;
    chk("drain_empty", b.out_valid, 0);
    chk("drain_addr", b.out_addr, 6);
    // SW and BEQ encodings
    req(3'd5, 5'd31, 5'd1, 5'd0, 6'd0, 26'h000_8000);
    step();
    req(3'd2, 5'd2, 5'd3, 5'd0, 6'd0, 26'h3FF_FFFF);
    step();
    b.in_valid = 0;
    chk("sw_instr", b.out_instr, 32'hAFE1_8000);
    b.out_ready = 1;
    step();
    b.out_ready = 0;
    chk("beq_instr", b.out_instr, 32'h1043_FFFF);
    b.out_ready = 1;
    step();
    b.out_ready = 0;
    // illegal class
    req(3'd7, 5'd5, 5'd5, 5'd5, 6'h3F, 26'h3FF_FFFF);
    step();
    b.in_valid = 0;
    chk("ill_instr", b.out_instr, 0);
    chk("ill_level", level, 1);
    chk("ill_err", err, EXP_ERR);
    step();
    chk("ill_err_sticky", err, EXP_ERR);
    clear = 1;
    req(3'd0, 5'd1, 5'd1, 5'd1, 6'd1, 26'd0);
    b.out_ready = 1;
    step();
    clear = 0;
    b.in_valid = 0;
    b.out_ready = 0;
    chk("clr_err", err, 0);
    chk("clr_level", level, 0);
    chk("clr_addr", b.out_addr, 0);
    chk("clr_valid", b.out_valid, 0);
    // ADDR_W=2 address wrap
    for (int i = 0; i < 5; i++) begin
      b2.in_valid = 1; b2.in_class = 3'd0; b2.in_funct = 6'(i);
      step();
      b2.in_valid = 0;
      chk("wrap_addr", b2.out_addr, 32'(i % 4));
      chk("wrap_instr", b2.out_instr, 32'(i));
      b2.out_ready = 1;
      step();
      b2.out_ready = 0;
    end
    b2.in_valid = 1;
    step(); step();
    b2.in_valid = 0;
    chk("pre_rst_level", level2, 2);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_level", level2, 0);
    chk("mid_rst_valid", b2.out_valid, 0);
    chk("mid_rst_ready", b2.in_ready, 1);
    chk("mid_rst_addr", b2.out_addr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
